// File: rtl/apb_initiator_bridge.sv
// apb_initiator_bridge
// Turns a valid/ready request/response port into APB3 initiator transfers,
// one transfer in flight at a time, with a registered response.
//
// Build option: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles; a transfer that runs out of time completes with
// rsp_err=1 and rsp_rdata=0. Without the macro the bridge waits for pready
// indefinitely and TIMEOUT_CYCLES has no effect.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel=1, penable=0, exactly one cycle
// ACCESS | psel=1, penable=1, waiting for pready (or the timeout)
// RESP   | rsp_valid high, holding the response until rsp_ready

module apb_initiator_bridge #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic          i_req_write,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_psel,
  output logic          o_penable,
  output logic [AW-1:0] o_paddr,
  output logic          o_pwrite,
  output logic [DW-1:0] o_pwdata,
  input  logic [DW-1:0] i_prdata,
  input  logic          i_pready,
  input  logic          i_pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_capture_req;
  logic          w_access_done;
  logic          w_timeout_hit;
  logic          w_timeout;

  logic [AW-1:0] r_paddr;
  logic          r_pwrite;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;

`ifdef APB_TIMEOUT_EN
  // Count reaches the last allowed value on the TIMEOUT_CYCLES-th ACCESS cycle.
  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;

  // Wait-state counter: zero outside ACCESS, so it starts at 0 on entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_wait_cnt <= '0;
    end else if (!i_pready) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_wait_cnt == LP_WAIT_LAST);
`else
  // No timeout hardware in this build; the parameter is intentionally inert.
  localparam int unsigned LP_UNUSED_TIMEOUT = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and APB/handshake outputs decoded from the current state.
  always_comb begin
    w_state_nxt   = r_state;
    o_req_ready   = 1'b0;
    o_psel        = 1'b0;
    o_penable     = 1'b0;
    o_rsp_valid   = 1'b0;
    w_capture_req = 1'b0;
    w_access_done = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        o_req_ready = rstn;
        if (i_req_valid) begin
          w_capture_req = 1'b1;
          w_state_nxt   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        o_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        // A slave that answers on the limit cycle still completes normally.
        if (i_pready) begin
          w_access_done = 1'b1;
          w_state_nxt   = ST_RESP;
        end else if (w_timeout) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture: address, direction and write data stay put for the transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_capture_req) begin
      r_paddr  <= i_req_addr;
      r_pwrite <= i_req_write;
      r_pwdata <= i_req_write ? i_req_wdata : '0;
    end
  end

  // Response capture on ACCESS completion or timeout; held through RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access_done) begin
      r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
      r_rsp_err   <= i_pslverr;
    end else if (w_timeout_hit) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end
  end

  assign o_paddr     = r_paddr;
  assign o_pwrite    = r_pwrite;
  assign o_pwdata    = r_pwdata;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Testbench for apb_initiator_bridge: directed latency/backpressure/error/
// timeout/reset cases followed by randomized transfers. Expected responses are
// queued at issue time from a word-array model of the peripheral and checked
// by an independent response monitor; an APB slave model checks the bus side.

module tb_apb_initiator_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_req_write = 1'b0;
  logic [DW-1:0] i_req_wdata = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_psel;
  logic          o_penable;
  logic [AW-1:0] o_paddr;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic [DW-1:0] i_prdata = '0;
  logic          i_pready = 1'b0;
  logic          i_pslverr = 1'b0;

  apb_initiator_bridge #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_write(i_req_write), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_psel(o_psel), .o_penable(o_penable), .o_paddr(o_paddr),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] pwdata;
    int            waits;
    logic          err;
  } cfg_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  cfg_t          cfg_q[$];
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] slv_mem [16];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            rsp_mode = 0;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Queue slave behaviour and, if tracked, the expected response.
  task automatic push_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                          input int waits, input logic err, input bit track);
    cfg_t c;
    rsp_t r;
    int   idx;
    idx      = int'(addr[5:2]);
    c.addr   = addr;
    c.write  = wr;
    c.pwdata = wr ? wd : '0;
    c.waits  = waits;
    c.err    = err;
    cfg_q.push_back(c);
    if (track) begin
      if (wr) begin
        r.rdata = '0;
        if (!err) ref_mem[idx] = wd;
      end else begin
        r.rdata = ref_mem[idx];
      end
      r.err = err;
      exp_q.push_back(r);
    end
  endtask

  // Present one request and return #1 after the accepting edge (in SETUP).
  task automatic do_req(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input int waits, input logic err, input bit track);
    int guard;
    @(negedge clk);
    push_txn(addr, wr, wd, waits, err, track);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_write = wr;
    i_req_wdata = wd;
    guard = 0;
    while (!o_req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        fail_now("req_ready_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_write = 1'($urandom);
    i_req_wdata = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !o_req_ready) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) fail_now("drain_wait");
  endtask

  // Response consumer.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rsp_mode)
        0:       i_rsp_ready = ($urandom % 3) != 0;
        1:       i_rsp_ready = 1'b0;
        default: i_rsp_ready = 1'b1;
      endcase
    end
  end

  // Response monitor: compares each consumed response with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && o_rsp_valid && i_rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
        end
      end
    end
  end

  // APB slave model: scripted wait states/errors, bus stability checks.
  initial begin
    cfg_t cur;
    bit   act;
    int   left;
    int   cnt;
    int   idx;
    act  = 0;
    left = 0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        act      = 0;
        i_pready = 1'b0;
      end else if (o_psel && !o_penable) begin
        if (cfg_q.size() == 0) begin
          fail_now("slave_unexpected_setup");
          act = 0;
        end else begin
          cur  = cfg_q.pop_front();
          act  = 1;
          left = cur.waits;
          cnt  = 0;
        end
        i_pready  = 1'($urandom);
        i_prdata  = $urandom;
        i_pslverr = 1'($urandom);
      end else if (o_psel && o_penable && act) begin
        cnt++;
        chk("apb_paddr", 64'(o_paddr), 64'(cur.addr));
        chk("apb_pwrite", 64'(o_pwrite), 64'(cur.write));
        chk("apb_pwdata", 64'(o_pwdata), 64'(cur.pwdata));
        if (left > 0) begin
          left--;
          i_pready  = 1'b0;
          i_prdata  = $urandom;
          i_pslverr = 1'($urandom);
        end else begin
          idx       = int'(o_paddr[5:2]);
          i_pready  = 1'b1;
          i_pslverr = cur.err;
          i_prdata  = cur.write ? $urandom : slv_mem[idx];
          if (cur.write && !cur.err) slv_mem[idx] = cur.pwdata;
          chk("access_cycles", 64'(cnt), 64'(cur.waits + 1));
          act = 0;
        end
      end else begin
        i_pready  = 1'($urandom);
        i_prdata  = $urandom;
        i_pslverr = 1'($urandom);
      end
    end
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] r0;
    logic          e0;
    int            g;
    int            n_acc;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    slv_mem[4] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'h0000_1234;
    slv_mem[5] = 32'h0000_1234;

    // Reset values.
    #3;
    chk("rst_req_ready", 64'(o_req_ready), 64'd0);
    chk("rst_psel", 64'(o_psel), 64'd0);
    chk("rst_penable", 64'(o_penable), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(o_rsp_err), 64'd0);
    chk("rst_paddr", 64'(o_paddr), 64'd0);
    chk("rst_pwrite", 64'(o_pwrite), 64'd0);
    chk("rst_pwdata", 64'(o_pwdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("idle_req_ready", 64'(o_req_ready), 64'd1);

    // Zero-wait write: cycle-exact latency.
    rsp_mode = 1;
    @(posedge clk);
    do_req(32'h0000_0004, 1'b1, 32'h0000_00FF, 0, 1'b0, 1'b1);
    chk("lat_setup_psel", 64'(o_psel), 64'd1);
    chk("lat_setup_penable", 64'(o_penable), 64'd0);
    chk("lat_setup_paddr", 64'(o_paddr), 64'h4);
    chk("lat_setup_pwdata", 64'(o_pwdata), 64'hFF);
    chk("lat_setup_pwrite", 64'(o_pwrite), 64'd1);
    @(posedge clk);
    #1;
    chk("lat_access_psel", 64'(o_psel), 64'd1);
    chk("lat_access_penable", 64'(o_penable), 64'd1);
    chk("lat_access_paddr", 64'(o_paddr), 64'h4);
    chk("lat_access_pwdata", 64'(o_pwdata), 64'hFF);
    chk("lat_access_pwrite", 64'(o_pwrite), 64'd1);
    @(posedge clk);
    #1;
    chk("lat_resp_valid", 64'(o_rsp_valid), 64'd1);
    chk("lat_resp_psel", 64'(o_psel), 64'd0);
    chk("lat_resp_penable", 64'(o_penable), 64'd0);
    chk("lat_resp_req_ready", 64'(o_req_ready), 64'd0);
    rsp_mode = 2;
    drain();

    // Read with three wait states (garbage prdata while waiting).
    do_req(32'h0000_0010, 1'b0, 32'h5555_AAAA, 3, 1'b0, 1'b1);
    drain();

    // Slave error on a read.
    do_req(32'h0000_0014, 1'b0, 32'h0, 0, 1'b1, 1'b1);
    drain();

    // Response backpressure with a second request already waiting.
    rsp_mode = 1;
    @(posedge clk);
    do_req(32'h0000_0018, 1'b0, 32'h0, 1, 1'b0, 1'b1);
    push_txn(32'h0000_001C, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b1);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_001C;
    i_req_write = 1'b1;
    i_req_wdata = 32'hA5A5_0001;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!o_rsp_valid && g < 50);
    if (g >= 50) fail_now("bp_rsp_valid_wait");
    r0 = o_rsp_rdata;
    e0 = o_rsp_err;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
      chk("bp_req_ready", 64'(o_req_ready), 64'd0);
      chk("bp_psel", 64'(o_psel), 64'd0);
      chk("bp_rdata_stable", 64'(o_rsp_rdata), 64'(r0));
      chk("bp_err_stable", 64'(o_rsp_err), 64'(e0));
    end
    @(posedge clk);
    #1;
    rsp_mode = 2;
    @(posedge clk);
    #1;
    chk("bp_req_ready_after", 64'(o_req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_second_setup_psel", 64'(o_psel), 64'd1);
    chk("bp_second_setup_penable", 64'(o_penable), 64'd0);
    i_req_valid = 1'b0;
    drain();

`ifdef APB_TIMEOUT_EN
    // Stuck slave: exactly TO ACCESS cycles, then error with zero data.
    do_req(32'h0000_0020, 1'b0, 32'h0, 100000, 1'b0, 1'b0);
    begin
      rsp_t t;
      t.rdata = '0;
      t.err   = 1'b1;
      exp_q.push_back(t);
    end
    n_acc = 0;
    g = 0;
    while (!o_rsp_valid && g < 200) begin
      @(negedge clk);
      if (o_psel && o_penable) n_acc++;
      g++;
    end
    chk("timeout_access_cycles", 64'(n_acc), 64'(TO));
    drain();
`else
    // Stuck slave without a timeout: the bridge keeps waiting.
    do_req(32'h0000_0020, 1'b0, 32'h0, 100000, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    chk("no_timeout_psel", 64'(o_psel), 64'd1);
    chk("no_timeout_penable", 64'(o_penable), 64'd1);
    chk("no_timeout_rsp_valid", 64'(o_rsp_valid), 64'd0);
    #2;
    rstn = 1'b0;
    #1;
    cfg_q.delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    #1;
`endif

    // Asynchronous reset in the middle of ACCESS.
    do_req(32'h0000_0024, 1'b0, 32'h0, 10, 1'b0, 1'b0);
    g = 0;
    while (!o_penable && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rst_mid_in_access", 64'(o_penable), 64'd1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_psel", 64'(o_psel), 64'd0);
    chk("rst_mid_penable", 64'(o_penable), 64'd0);
    chk("rst_mid_rsp_valid", 64'(o_rsp_valid), 64'd0);
    cfg_q.delete();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_mid_req_ready", 64'(o_req_ready), 64'd1);

    // Randomized traffic against the word-array model.
    rsp_mode = 0;
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      logic          w;
      logic [DW-1:0] d;
      a = $urandom;
      w = 1'($urandom);
      d = $urandom;
      do_req(a, w, d, int'($urandom_range(0, 5)), 1'(($urandom % 8) == 0), 1'b1);
      if (($urandom % 4) == 0) drain();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_initiator_bridge.md
Name: apb_initiator_bridge

Overview:
- Converts a simple valid/ready request/response port into APB3 initiator transfers.
- Lets a local agent (debug loader, DMA, test sequencer) reach APB peripherals in the subsystem, such as the interrupt controller, timer and UART register blocks.
- One transfer in flight at a time, with a registered response channel.

Parameters:
- AW, 32, address width of req_addr and paddr.
- DW, 32, data width of wdata/rdata paths.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error (used only with APB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_addr  input  AW  byte address; bits [1:0] forwarded unchanged.
- req_write  input  1  1=write, 0=read.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  DW  read data; 0 for writes.
- rsp_err  output  1  pslverr or timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- paddr  output  AW  APB address.
- pwrite  output  1  APB direction.
- pwdata  output  DW  APB write data.
- prdata  input  DW  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0; req_ready is 1 combinationally in IDLE only.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/write/wdata into paddr/pwrite/pwdata (write data registered only when req_write=1, else pwdata=0) and go to SETUP.
- SETUP:
  - psel=1, penable=0; exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - If pready=1: capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr; drop psel/penable next cycle; go to RESP.
  - If pready=0: stay in ACCESS and count wait cycles.
- RESP:
  - rsp_valid=1, psel=0; rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_ready, return to IDLE; rsp_valid=0 next cycle.
  - No new request is accepted in RESP, so there are no back-to-back overlapping transfers.
- Latency with a zero-wait-state slave:
  - Request accepted in cycle N.
  - SETUP in N+1, ACCESS in N+2, rsp_valid in N+3.
  - Next req_ready no earlier than the cycle after rsp_ready.
- pslverr is sampled only when psel & penable & pready; it is ignored otherwise.
- prdata is sampled only on ACCESS completion of a read.
- req_valid deasserting without handshake has no effect; requests are never dropped once accepted.
- Asynchronous reset mid-transfer:
  - psel/penable clear immediately, FSM returns to IDLE, the pending response is discarded.
  - The slave sees an aborted transfer, which is acceptable per system reset policy.
- pready high during SETUP is ignored.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 and pready is still 0, the transfer terminates: go to RESP with rsp_err=1 and rsp_rdata=0, and drop psel/penable.
  - pready=1 on the same cycle as the limit wins: normal completion using pslverr.
- Not defined:
  - No counter is present; the FSM waits in ACCESS indefinitely for pready.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Write, pready tied 1: req addr=0x04, wdata=0x0000_00FF, write=1 -> psel rises N+1, penable N+2, paddr=0x04, pwdata=0xFF, pwrite=1 stable both cycles; rsp_valid N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: pready low 3 ACCESS cycles, then prdata=0xDEAD_BEEF -> penable held 4 cycles; rsp_rdata=0xDEADBEEF, rsp_err=0; prdata changes during wait cycles do not affect the result.
- Slave error: read completes with pready=1, pslverr=1, prdata=0x1234 -> rsp_err=1, rsp_rdata=0x1234.
- Response backpressure: rsp_ready low 5 cycles with req_valid held high -> rsp_valid and data stable, req_ready=0 throughout, psel=0; second request accepted the cycle after rsp_ready.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, pready stuck 0) -> exactly 8 ACCESS cycles, then rsp_err=1, rsp_rdata=0. Without the macro, psel/penable remain high after 1000 cycles.
- Reset mid-ACCESS: assert rstn=0 while penable=1 -> psel, penable, rsp_valid all 0 asynchronously; after release, req_ready=1 and the next transfer completes normally.
